// File: rtl/sevenseg_scan_mux.sv
// Four-digit common-anode scanner with guard-blanked slots and frame-aligned value commits.
// All outputs are registered and lag the scan state by one cycle. There is no backpressure: the scan free-runs.
module sevenseg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        lz_en,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  hex_out,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_v;

  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic [3:0]    supp;
  logic          in_window;
  logic          visible;

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    boundary  = slot_end && (idx == 2'd3);
    nib       = active[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and everything above it are zero.
    supp[0]   = 1'b0;
    supp[1]   = lz_en && (active[15:4] == 12'd0);
    supp[2]   = lz_en && (active[15:8] == 8'd0);
    supp[3]   = lz_en && (active[15:12] == 4'd0);
    in_window = int'(cnt) >= GUARD;
    visible   = digit_en[idx] && in_window && !supp[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load that lands on the boundary bypasses the buffer so it is shown next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 16'd0;
      pending <= 16'd0;
      pend_v  <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        active <= value_in;
        pend_v <= 1'b0;
      end else if (pend_v) begin
        active <= pending;
        pend_v <= 1'b0;
      end
    end else if (load) begin
      pending <= value_in;
      pend_v  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out    <= 4'd0;
      an         <= 4'b1111;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      hex_out    <= nib;
      an         <= visible ? ~(4'b0001 << idx) : 4'b1111;
      dp_n       <= ~(dp_in[idx] & visible);
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Randomized and directed bench for sevenseg_scan_mux; a time-based display model feeds a
// queue of expected outputs that an independent monitor pops after every clock edge.
module tb_sevenseg_scan_mux;

  localparam int RD    = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [3:0] hex;
    logic [3:0] an;
    logic       dp_n;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = 16'd0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  digit_en = 4'd0;
  logic [3:0]  dp_in = 4'd0;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_done;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Model: t is cycles since reset release; shown is what the current frame displays,
  // latest is the most recent value loaded (what the next frame will display).
  int          t = 0;
  logic [15:0] shown = 16'd0;
  logic [15:0] latest = 16'd0;
  logic        rel_pend = 1'b1;
  logic        cfg_lz = 1'b0;
  logic [3:0]  cfg_en = 4'hF;
  logic [3:0]  cfg_dp = 4'h0;

  sevenseg_scan_mux #(.REFRESH_DIV(RD), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .lz_en      (lz_en),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .hex_out    (hex_out),
    .an         (an),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t (model cycle %0d): got %h expected %h", name, $time, t, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v);
    exp_t e;
    int   pos;
    int   slot;
    logic sup;
    logic vis;
    logic [15:0] upper;
    @(negedge clk);
    if (rel_pend) begin
      rst_n    = 1'b1;
      rel_pend = 1'b0;
    end
    load     = ld;
    value_in = v;
    lz_en    = cfg_lz;
    digit_en = cfg_en;
    dp_in    = cfg_dp;
    pos   = t % RD;
    slot  = (t / RD) % 4;
    upper = shown >> (4 * slot);
    sup   = cfg_lz && (slot != 0) && (upper == 16'd0);
    vis   = cfg_en[slot] && (pos >= GUARD) && !sup;
    e.hex  = upper[3:0];
    e.an   = vis ? 4'(~(32'd1 << slot)) : 4'hF;
    e.dp_n = !(cfg_dp[slot] && vis);
    e.fd   = (t % FRAME) == (FRAME - 1);
    q.push_back(e);
    if (ld) latest = v;
    if (e.fd) shown = latest;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) step(1'b0, 16'd0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    chk("rst_async_an", an, 4'hF);
    chk("rst_async_hex", hex_out, 4'h0);
    chk("rst_async_dp", {3'd0, dp_n}, 4'h1);
    chk("rst_async_fd", {3'd0, frame_done}, 4'h0);
    q.delete();
    t      = 0;
    shown  = 16'd0;
    latest = 16'd0;
    repeat (2) @(negedge clk);
    rel_pend = 1'b1;
  endtask

  // Monitor: every output update after an edge is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hex_out", hex_out, e.hex);
        chk("an", an, e.an);
        chk("dp_n", {3'd0, dp_n}, {3'd0, e.dp_n});
        chk("frame_done", {3'd0, frame_done}, {3'd0, e.fd});
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic        ld;
    logic [15:0] v;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_hex", hex_out, 4'h0);
    chk("rst_dp", {3'd0, dp_n}, 4'h1);
    chk("rst_fd", {3'd0, frame_done}, 4'h0);

    // Basic scan of BEEF over several frames.
    step(1'b1, 16'hBEEF);
    idle(3 * FRAME);

    // Leading-zero suppression.
    cfg_lz = 1'b1;
    step(1'b1, 16'h0042);
    idle(2 * FRAME);
    step(1'b1, 16'h0000);
    idle(2 * FRAME);
    step(1'b1, 16'h1002);
    idle(2 * FRAME);
    cfg_lz = 1'b0;

    // Tear-free update during slot 1, then two loads in one frame.
    step(1'b1, 16'h1111);
    run_to(0);
    run_to(RD + 3);
    step(1'b1, 16'h1234);
    idle(2 * FRAME);
    run_to(5);
    step(1'b1, 16'h5555);
    run_to(20);
    step(1'b1, 16'h6666);
    idle(2 * FRAME);

    // Load on the boundary, with a stale pending value that must never appear.
    run_to(10);
    step(1'b1, 16'h7777);
    run_to(FRAME - 1);
    step(1'b1, 16'hA5C3);
    idle(2 * FRAME);

    // Digit enable and decimal point.
    cfg_en = 4'b0101;
    cfg_dp = 4'b0111;
    step(1'b1, 16'h8888);
    idle(2 * FRAME);
    cfg_en = 4'hF;
    cfg_dp = 4'h0;

    // Asynchronous reset while digit 2 is lit.
    run_to(2 * RD + 4);
    async_reset();
    idle(2 * FRAME);

    // Randomized traffic with occasional configuration changes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        cfg_lz = 1'($urandom_range(0, 1));
        cfg_en = 4'($urandom_range(0, 15));
        cfg_dp = 4'($urandom_range(0, 15));
      end
      r  = $urandom;
      v  = r[15:0] >> (4 * $urandom_range(0, 4));
      ld = ($urandom_range(0, 11) == 0);
      step(ld, v);
    end

    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
